pipe_sfcontrol_gen: RTL and testbench

- Parametrised successor to the 5-stage stall/flush controller.
- Drives per-stage stall and flush vectors for an N-stage pipeline, including the PC register.
- Adds behaviour the previous block lacks:
  - a pending-redirect latch, so branch/trap pulses masked by a stall are never lost;
  - bubble insertion on load-use hazards;
  - a data-memory wait FSM with a timeout watchdog;
  - a saturating stall-cycle performance counter.

---
 rtl/pipe_sfcontrol_gen_if.sv | 27 ++
 rtl/pipe_sfcontrol_gen.sv | 134 +++++++++++++
 tb/tb_pipe_sfcontrol_gen.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_sfcontrol_gen_if.sv
// Control bundle between pipeline hazard sources and the stall/flush controller.
// master = request side (drives pulses/levels), slave = controller.
interface pipe_sfcontrol_gen_if #(
  parameter int NUM_STAGES = 5,
  parameter int CNT_WIDTH  = 32
);
  logic                  branch;
  logic                  trap;
  logic                  dmem_busy;
  logic                  imem_busy;
  logic                  hazard;
  logic [NUM_STAGES-1:0] stall;
  logic [NUM_STAGES-1:0] flush;
  logic                  redirect_pending;
  logic                  mem_timeout;
  logic [CNT_WIDTH-1:0]  stall_cycles;

  modport master (
    output branch, trap, dmem_busy, imem_busy, hazard,
    input  stall, flush, redirect_pending, mem_timeout, stall_cycles
  );

  modport slave (
    input  branch, trap, dmem_busy, imem_busy, hazard,
    output stall, flush, redirect_pending, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_sfcontrol_gen.sv
// Per-stage stall/flush controller for an N-stage pipeline; stall/flush are zero-latency.
// Memory/hazard stalls mask redirects, which are latched and issued once the pipe moves.
module pipe_sfcontrol_gen #(
  parameter int NUM_STAGES   = 5,
  parameter int BRANCH_STAGE = 2,
  parameter int HAZ_STAGE    = 2,
  parameter int MEM_STAGE    = 3,
  parameter int TIMEOUT      = 1024,
  parameter int CNT_WIDTH    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  pipe_sfcontrol_gen_if.slave ctl
);

  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  function automatic logic [NUM_STAGES-1:0] low_mask(input int hi);
    logic [NUM_STAGES-1:0] m;
    m = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (s <= hi) m[s] = 1'b1;
    end
    return m;
  endfunction

  logic [0:0]           state_q, state_d;
  logic [WW-1:0]        wait_cnt_q, wait_cnt_d;
  logic                 pend_branch_q, pend_branch_d;
  logic                 pend_trap_q, pend_trap_d;
  logic                 mem_timeout_q, mem_timeout_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  logic                  eff_trap, eff_branch, blocked;
  logic [NUM_STAGES-1:0] stall_v, flush_v;

  assign eff_trap   = ctl.trap | pend_trap_q;
  assign eff_branch = (ctl.branch | pend_branch_q) & ~eff_trap;
  assign blocked    = ctl.dmem_busy | ctl.hazard | ctl.imem_busy;

  always_comb begin
    stall_v = '0;
    flush_v = '0;
    if (ctl.dmem_busy) begin
      stall_v              = low_mask(MEM_STAGE);
      flush_v[MEM_STAGE+1] = 1'b1;
    end else if (ctl.hazard) begin
      stall_v              = low_mask(HAZ_STAGE);
      flush_v[HAZ_STAGE+1] = 1'b1;
    end else if (ctl.imem_busy) begin
      stall_v[0] = 1'b1;
      flush_v[1] = 1'b1;
    end else if (eff_trap) begin
      flush_v = low_mask(MEM_STAGE);
    end else if (eff_branch) begin
      flush_v = low_mask(BRANCH_STAGE);
    end
  end

  // Pulses seen while stalled are OR-ed into the latch, so a repeat pulse is absorbed.
  always_comb begin
    pend_branch_d = pend_branch_q;
    pend_trap_d   = pend_trap_q;
    if (blocked) begin
      pend_branch_d = pend_branch_q | ctl.branch;
      pend_trap_d   = pend_trap_q | ctl.trap;
    end else if (eff_trap) begin
      pend_branch_d = 1'b0;
      pend_trap_d   = 1'b0;
    end else if (eff_branch) begin
      pend_branch_d = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (ctl.dmem_busy) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WW'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (ctl.dmem_busy) begin
          if (wait_cnt_q != WW'(TIMEOUT)) wait_cnt_d = wait_cnt_q + WW'(1);
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  assign mem_timeout_d = mem_timeout_q | (wait_cnt_d == WW'(TIMEOUT));

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_v[0] && (stall_cnt_q != {CNT_WIDTH{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      pend_branch_q <= 1'b0;
      pend_trap_q   <= 1'b0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      pend_branch_q <= pend_branch_d;
      pend_trap_q   <= pend_trap_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign ctl.stall            = stall_v;
  assign ctl.flush            = flush_v;
  assign ctl.redirect_pending = pend_branch_q | pend_trap_q;
  assign ctl.mem_timeout      = mem_timeout_q;
  assign ctl.stall_cycles     = stall_cnt_q;

endmodule

// File: tb/tb_pipe_sfcontrol_gen.sv
// Scoreboarded bench for pipe_sfcontrol_gen: per-cycle stall/flush/pending expectations
// are queued at drive time and compared on the falling edge.
module tb_pipe_sfcontrol_gen;

  logic clk;
  logic reset_n;

  pipe_sfcontrol_gen_if #(.NUM_STAGES(5), .CNT_WIDTH(3)) bus ();

  pipe_sfcontrol_gen #(
    .NUM_STAGES(5), .BRANCH_STAGE(2), .HAZ_STAGE(2), .MEM_STAGE(3),
    .TIMEOUT(4), .CNT_WIDTH(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ctl(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] st;
    logic [4:0] fl;
    logic       rp;
    int         id;
  } exp_t;

  exp_t sb[$];
  int   n_id  = 0;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk($sformatf("stall#%0d", e.id), 32'(bus.stall), 32'(e.st));
      chk($sformatf("flush#%0d", e.id), 32'(bus.flush), 32'(e.fl));
      chk($sformatf("rpend#%0d", e.id), 32'(bus.redirect_pending), 32'(e.rp));
    end
  end

  // One cycle of stimulus: branch, trap, dmem_busy, imem_busy, hazard, plus expectations.
  task automatic cyc(input logic b, input logic t, input logic d, input logic i, input logic h,
                     input logic [4:0] es, input logic [4:0] ef, input logic erp);
    exp_t e;
    @(posedge clk);
    #1;
    bus.branch    = b;
    bus.trap      = t;
    bus.dmem_busy = d;
    bus.imem_busy = i;
    bus.hazard    = h;
    e.st = es;
    e.fl = ef;
    e.rp = erp;
    e.id = n_id;
    n_id++;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    bus.branch    = 1'b0;
    bus.trap      = 1'b0;
    bus.dmem_busy = 1'b0;
    bus.imem_busy = 1'b0;
    bus.hazard    = 1'b0;
    reset_n = 1'b0;
    #2;
    chk("rst_stall_cycles", 32'(bus.stall_cycles), 32'd0);
    chk("rst_mem_timeout", 32'(bus.mem_timeout), 32'd0);
    chk("rst_rpend", 32'(bus.redirect_pending), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_flush", 32'(bus.flush), 32'd0);
    reset_n = 1'b1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.branch    = 1'b0;
    bus.trap      = 1'b0;
    bus.dmem_busy = 1'b0;
    bus.imem_busy = 1'b0;
    bus.hazard    = 1'b0;
    do_reset();

    // Idle after reset
    for (int k = 0; k < 10; k++) cyc(0,0,0,0,0, 5'b00000, 5'b00000, 0);
    at_neg();
    chk("idle_stall_cycles", 32'(bus.stall_cycles), 32'd0);

    // Lone branch pulse
    cyc(1,0,0,0,0, 5'b00000, 5'b00111, 0);
    cyc(0,0,0,0,0, 5'b00000, 5'b00000, 0);

    // dmem wait of 4 cycles, branch masked in cycle 2, issued in cycle 5
    do_reset();
    cyc(0,0,1,0,0, 5'b01111, 5'b10000, 0);
    cyc(1,0,1,0,0, 5'b01111, 5'b10000, 0);
    cyc(0,0,1,0,0, 5'b01111, 5'b10000, 1);
    cyc(0,0,1,0,0, 5'b01111, 5'b10000, 1);
    at_neg();
    chk("to_before_4th_edge", 32'(bus.mem_timeout), 32'd0);
    cyc(0,0,0,0,0, 5'b00000, 5'b00111, 1);
    cyc(0,0,0,0,0, 5'b00000, 5'b00000, 0);
    at_neg();
    chk("dmem4_stall_cycles", 32'(bus.stall_cycles), 32'd4);
    chk("dmem4_timeout", 32'(bus.mem_timeout), 32'd1);

    // Masked branch then masked trap under hazard: only the trap redirect issues
    do_reset();
    cyc(1,0,0,0,1, 5'b00111, 5'b01000, 0);
    cyc(0,1,0,0,1, 5'b00111, 5'b01000, 1);
    cyc(0,0,0,0,0, 5'b00000, 5'b01111, 1);
    cyc(0,0,0,0,0, 5'b00000, 5'b00000, 0);
    cyc(0,0,0,0,0, 5'b00000, 5'b00000, 0);

    // Single hazard cycle, imem stall, and priority of dmem over everything
    cyc(0,0,0,0,1, 5'b00111, 5'b01000, 0);
    cyc(0,0,0,1,0, 5'b00001, 5'b00010, 0);
    cyc(0,0,1,1,1, 5'b01111, 5'b10000, 0);
    cyc(0,0,0,1,1, 5'b00111, 5'b01000, 0);

    // Trap masked by imem; a fresh trap on the issue cycle is absorbed
    cyc(0,1,0,1,0, 5'b00001, 5'b00010, 0);
    cyc(0,1,0,0,0, 5'b00000, 5'b01111, 1);
    cyc(0,0,0,0,0, 5'b00000, 5'b00000, 0);

    // Simultaneous trap and branch: trap wins, branch is dropped
    cyc(1,1,0,0,0, 5'b00000, 5'b01111, 0);
    cyc(0,0,0,0,0, 5'b00000, 5'b00000, 0);

    // Three busy cycles stay below the timeout
    do_reset();
    for (int k = 0; k < 3; k++) cyc(0,0,1,0,0, 5'b01111, 5'b10000, 0);
    cyc(0,0,0,0,0, 5'b00000, 5'b00000, 0);
    at_neg();
    chk("dmem3_timeout", 32'(bus.mem_timeout), 32'd0);

    // Six busy cycles: timeout rises after the 4th and sticks
    do_reset();
    for (int k = 0; k < 4; k++) cyc(0,0,1,0,0, 5'b01111, 5'b10000, 0);
    at_neg();
    chk("dmem6_to_c4", 32'(bus.mem_timeout), 32'd0);
    cyc(0,0,1,0,0, 5'b01111, 5'b10000, 0);
    at_neg();
    chk("dmem6_to_c5", 32'(bus.mem_timeout), 32'd1);
    cyc(0,0,1,0,0, 5'b01111, 5'b10000, 0);
    cyc(0,0,0,0,0, 5'b00000, 5'b00000, 0);
    cyc(0,0,0,0,0, 5'b00000, 5'b00000, 0);
    at_neg();
    chk("dmem6_to_sticky", 32'(bus.mem_timeout), 32'd1);
    chk("stall_cnt_sat", 32'(bus.stall_cycles), 32'd6);

    // Counter saturates at all-ones
    cyc(0,0,0,1,0, 5'b00001, 5'b00010, 0);
    cyc(0,0,0,1,0, 5'b00001, 5'b00010, 0);
    cyc(0,0,0,0,0, 5'b00000, 5'b00000, 0);
    at_neg();
    chk("stall_cnt_full", 32'(bus.stall_cycles), 32'd7);

    // Reset mid-pending discards the latched redirect
    cyc(1,0,1,0,0, 5'b01111, 5'b10000, 0);
    cyc(0,0,1,0,0, 5'b01111, 5'b10000, 1);
    do_reset();
    cyc(0,0,0,0,0, 5'b00000, 5'b00000, 0);
    cyc(0,0,0,0,0, 5'b00000, 5'b00000, 0);

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) chk("sb_drain", 32'(sb.size()), 32'd0);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
